sprite_rom_arbiter: RTL and testbench

- Shares one synchronous sprite ROM read port between up to NUM_REQ sprite fetch units (e.g. fireboy/watergirl head and body layers) in the VGA pixel pipeline.
- Round-robin arbitration with optional bounded burst lock. It issues the registered ROM address and tracks in-flight reads through a ROM_LAT-deep tag pipeline.
- Each returned palette index is delivered with the requester ID, ready for the per-sprite palette lookup.

---
 rtl/sprite_rom_arbiter_if.sv | 39 +++
 rtl/sprite_rom_arbiter.sv | 149 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_rom_arbiter_if.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter_if
// Bundles the sprite fetch request bus, the shared ROM read port and the
// response bus used by sprite_rom_arbiter.
//   req/req_addr/lock : per-requester read requests (fetch units -> arbiter)
//   gnt               : one-hot combinational grant (arbiter -> fetch units)
//   rom_addr/rom_en   : registered ROM read port (arbiter -> ROM)
//   rom_q             : ROM read data (ROM -> arbiter)
//   rsp_*             : returned palette index tagged with requester id
// The slave modport is the arbiter's view; master is the surrounding system.
// ---------------------------------------------------------------------------
interface sprite_rom_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 15,
   parameter int DATA_W  = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        lock;
   logic [NUM_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]         rom_addr;
   logic                      rom_en;
   logic [DATA_W-1:0]         rom_q;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [DATA_W-1:0]         rsp_data;

   modport master (
      output req, req_addr, lock, rom_q,
      input  gnt, rom_addr, rom_en, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req, req_addr, lock, rom_q,
      output gnt, rom_addr, rom_en, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one synchronous sprite ROM read port between NUM_REQ sprite fetch
// units. Round-robin arbitration with a bounded burst lock; the granted
// address is registered onto the ROM port and the requester id travels
// through a ROM_LAT-deep tag pipeline so each ROM word comes back tagged.
// Ports:
//   vga_clk  : pixel clock, all state changes on its rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : sprite_rom_arbiter_if.slave (request, ROM and response buses)
// ---------------------------------------------------------------------------
module sprite_rom_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 15,
   parameter int DATA_W   = 4,
   parameter int ROM_LAT  = 1,
   parameter int LOCK_MAX = 8
) (
   input logic                vga_clk,
   input logic                reset_n,
   sprite_rom_arbiter_if.slave bus
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [ID_W-1:0]  LAST_RST   = ID_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

   logic [ID_W-1:0]   last_id_q, last_id_d;
   logic              locked_q, locked_d;
   logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              rom_en_q, rom_en_d;
   logic [ROM_LAT-1:0] tag_vld_q, tag_vld_d;
   logic [ID_W-1:0]   tag_id_q [ROM_LAT];
   logic [ID_W-1:0]   tag_id_d [ROM_LAT];
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              other_req;
   logic              hold;
   logic              gnt_any;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   cand;

   // Arbitration: the lock holder keeps the port while it is under its burst
   // budget, or beyond it when nobody else is asking; otherwise rotate.
   always_comb begin
      other_req = |(bus.req & ~(NUM_REQ'(1) << last_id_q));
      hold      = locked_q && bus.req[last_id_q] &&
                  ((lock_cnt_q < LOCK_MAX_C) || !other_req);
      gnt_any   = 1'b0;
      gnt_id    = last_id_q;
      cand      = last_id_q;
      if (hold) begin
         gnt_any = 1'b1;
      end else begin
         // k runs to NUM_REQ so the previous winner is searched last.
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_id_q) + k) % NUM_REQ);
            if (!gnt_any && bus.req[cand]) begin
               gnt_any = 1'b1;
               gnt_id  = cand;
            end
         end
      end
      if (!reset_n) begin
         gnt_any = 1'b0;
      end
   end

   assign bus.gnt = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;

   always_comb begin
      last_id_d   = last_id_q;
      locked_d    = 1'b0;
      lock_cnt_d  = '0;
      rom_addr_d  = rom_addr_q;
      rom_en_d    = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;

      // Stage 0: accepted grant drives the ROM port and enters the tag pipe
      if (gnt_any) begin
         rom_addr_d = bus.req_addr[gnt_id*ADDR_W +: ADDR_W];
         rom_en_d   = 1'b1;
         last_id_d  = gnt_id;
         if (gnt_id == last_id_q && locked_q) begin
            lock_cnt_d = (lock_cnt_q == LOCK_MAX_C) ? lock_cnt_q
                                                    : CNT_W'(lock_cnt_q + 1'b1);
         end else begin
            lock_cnt_d = CNT_W'(1);
         end
         locked_d = bus.lock[gnt_id];
      end

      tag_vld_d[0] = gnt_any;
      tag_id_d[0]  = gnt_id;
      // Stages 1..ROM_LAT-1: tag follows the read through the ROM latency
      for (int i = 1; i < ROM_LAT; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end

      // Response stage: ROM word is valid while the last tag stage is
      if (tag_vld_q[ROM_LAT-1]) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = tag_id_q[ROM_LAT-1];
         rsp_data_d  = bus.rom_q;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         last_id_q   <= LAST_RST;
         locked_q    <= 1'b0;
         lock_cnt_q  <= '0;
         rom_addr_q  <= '0;
         rom_en_q    <= 1'b0;
         tag_vld_q   <= '0;
         for (int i = 0; i < ROM_LAT; i++) begin
            tag_id_q[i] <= '0;
         end
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         last_id_q   <= last_id_d;
         locked_q    <= locked_d;
         lock_cnt_q  <= lock_cnt_d;
         rom_addr_q  <= rom_addr_d;
         rom_en_q    <= rom_en_d;
         tag_vld_q   <= tag_vld_d;
         for (int i = 0; i < ROM_LAT; i++) begin
            tag_id_q[i] <= tag_id_d[i];
         end
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign bus.rom_addr  = rom_addr_q;
   assign bus.rom_en    = rom_en_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_rom_arbiter
// Two arbiters (ROM_LAT=1 and ROM_LAT=3) share one request stream. A
// reference model predicts every grant; each grant is queued and a monitor
// checks ROM strobes and responses of both instances against the queue.
// ---------------------------------------------------------------------------
module tb_sprite_rom_arbiter;
   localparam int NR = 4;
   localparam int AW = 15;
   localparam int DW = 4;
   localparam int LOCK_MAX = 8;

   typedef struct {
      int id;
      int data;
      int addr;
      int gcyc;
   } exp_t;

   logic           clk;
   logic           reset_n;
   logic [NR-1:0]  req;
   logic [NR-1:0]  lock;
   logic [NR*AW-1:0] req_addr;
   int             cyc;
   int             n_tests;
   int             n_fail;

   exp_t gq[$];
   int   pa, p1, p3;
   logic [NR-1:0] exp_gnt;
   logic [NR-1:0] obs_gnt;
   logic [NR-1:0] hist[$];

   int  m_last;
   int  m_streak;
   bit  m_locked;

   logic [AW-1:0] d1, d2;
   bit e;

   sprite_rom_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) b1 ();
   sprite_rom_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) b3 ();

   sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1),
                        .LOCK_MAX(LOCK_MAX)) u_lat1 (
      .vga_clk(clk), .reset_n(reset_n), .bus(b1.slave));

   sprite_rom_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3),
                        .LOCK_MAX(LOCK_MAX)) u_lat3 (
      .vga_clk(clk), .reset_n(reset_n), .bus(b3.slave));

   function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ {1'b0, a[14:12]} ^ 4'h5;
   endfunction

   assign b1.req = req;      assign b3.req = req;
   assign b1.lock = lock;    assign b3.lock = lock;
   assign b1.req_addr = req_addr;
   assign b3.req_addr = req_addr;
   // ROM models: data appears ROM_LAT-1 cycles after the address is presented
   assign b1.rom_q = rom_fn(b1.rom_addr);
   always @(posedge clk) begin
      d1 <= b3.rom_addr;
      d2 <= d1;
   end
   assign b3.rom_q = rom_fn(d2);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: the requester that last won keeps the port if it asked
   // to stay locked, still wants it, and either its unbroken run is shorter
   // than LOCK_MAX or nobody else is waiting. Otherwise the next requester
   // after the last winner, in circular order, takes it.
   function automatic int model_pick(input logic [NR-1:0] r);
      bit others = 1'b0;
      for (int i = 0; i < NR; i++) if (i != m_last && r[i]) others = 1'b1;
      if (m_locked && r[m_last] && (m_streak < LOCK_MAX || !others)) return m_last;
      for (int k = 1; k <= NR; k++) if (r[(m_last + k) % NR]) return (m_last + k) % NR;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = NR - 1;
      m_streak = 0;
      m_locked = 1'b0;
   endtask

   task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input logic [NR*AW-1:0] a);
      int g;
      logic [AW-1:0] ga;
      @(posedge clk);
      #1;
      req = r; lock = l; req_addr = a;
      g = model_pick(r);
      if (g >= 0) begin
         ga = a[g*AW +: AW];
         gq.push_back('{id: g, data: int'(rom_fn(ga)), addr: int'(ga), gcyc: cyc});
         m_streak = (g == m_last && m_locked) ? m_streak + 1 : 1;
         m_locked = l[g];
         m_last = g;
         exp_gnt = NR'(1) << g;
      end else begin
         m_locked = 1'b0;
         m_streak = 0;
         exp_gnt = '0;
      end
      #1;
      chk("gnt_lat1", b1.gnt, exp_gnt);
      chk("gnt_lat3", b3.gnt, exp_gnt);
      obs_gnt = b1.gnt;
      hist.push_back(obs_gnt);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      req = '1;
      #1;
      chk("rst_rom_en",    {b1.rom_en, b3.rom_en}, 0);
      chk("rst_rom_addr",  {b1.rom_addr, b3.rom_addr}, 0);
      chk("rst_rsp_valid", {b1.rsp_valid, b3.rsp_valid}, 0);
      chk("rst_rsp_id",    {b1.rsp_id, b3.rsp_id}, 0);
      chk("rst_rsp_data",  {b1.rsp_data, b3.rsp_data}, 0);
      chk("rst_gnt",       {b1.gnt, b3.gnt}, 0);
      pa = gq.size(); p1 = gq.size(); p3 = gq.size();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      req = '0;
      reset_n = 1'b1;
      obs_gnt = '0;
   endtask

   // Monitor: every cycle, ROM strobe and responses must match queued grants
   always @(negedge clk) begin
      if (reset_n) begin
         e = (pa < gq.size()) && (gq[pa].gcyc + 1 == cyc);
         chk("rom_en_lat1", b1.rom_en, e);
         chk("rom_en_lat3", b3.rom_en, e);
         if (e) begin
            chk("rom_addr_lat1", b1.rom_addr, gq[pa].addr);
            chk("rom_addr_lat3", b3.rom_addr, gq[pa].addr);
            pa++;
         end
         e = (p1 < gq.size()) && (gq[p1].gcyc + 2 == cyc);
         chk("rsp_valid_lat1", b1.rsp_valid, e);
         if (e) begin
            chk("rsp_id_lat1", b1.rsp_id, gq[p1].id);
            chk("rsp_data_lat1", b1.rsp_data, gq[p1].data);
            p1++;
         end
         e = (p3 < gq.size()) && (gq[p3].gcyc + 4 == cyc);
         chk("rsp_valid_lat3", b3.rsp_valid, e);
         if (e) begin
            chk("rsp_id_lat3", b3.rsp_id, gq[p3].id);
            chk("rsp_data_lat3", b3.rsp_data, gq[p3].data);
            p3++;
         end
      end
   end

   initial begin
      logic [NR-1:0] seq_rr [8];
      logic [NR-1:0] r;
      int base;
      n_tests = 0; n_fail = 0; cyc = 0;
      pa = 0; p1 = 0; p3 = 0;
      reset_n = 1'b0; req = '0; lock = '0; req_addr = '0; obs_gnt = '0;
      model_reset();
      do_reset();

      // Single read from requester 0
      drive(4'b0001, 4'b0000, 60'h0123);
      chk("first_gnt", obs_gnt, 4'b0001);
      repeat (3) drive(4'b0000, 4'b0000, '0);

      // Plain round robin over all four requesters
      do_reset();
      seq_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      base = hist.size();
      for (int i = 0; i < 8; i++)
         drive(4'b1111, 4'b0000, {15'h4444, 15'h3333, 15'h2222, 15'h1111 + 15'(i)});
      for (int i = 0; i < 8; i++) chk("rr_order", hist[base + i], seq_rr[i]);

      // Locked requester 0 competing with requester 1
      do_reset();
      base = hist.size();
      for (int i = 0; i < 12; i++)
         drive(4'b0011, 4'b0001, {30'h0, 15'h0A00 + 15'(i), 15'h0500 + 15'(i)});
      for (int i = 0; i < 8; i++) chk("lock_burst", hist[base + i], 4'b0001);
      chk("lock_yield", hist[base + 8], 4'b0010);
      chk("lock_resume", hist[base + 9], 4'b0001);

      // Locked requester 0 alone, gap, then 0 and 2 together
      drive(4'b0000, 4'b0000, '0);
      for (int i = 0; i < 12; i++) drive(4'b0001, 4'b0001, 60'(15'h0100 + 15'(i)));
      chk("lock_alone", obs_gnt, 4'b0001);
      drive(4'b0000, 4'b0001, '0);
      drive(4'b0101, 4'b0001, {15'h0, 15'h2BCD, 15'h0, 15'h1111});
      chk("gap_rotate", obs_gnt, 4'b0100);
      repeat (5) drive(4'b0000, 4'b0000, '0);

      // Reset while a read is in flight
      drive(4'b0010, 4'b0000, {15'h0, 15'h0, 15'h3456, 15'h0});
      do_reset();
      drive(4'b1111, 4'b0000, {15'h11, 15'h22, 15'h33, 15'h44});
      chk("post_rst_gnt", obs_gnt, 4'b0001);
      repeat (5) drive(4'b0000, 4'b0000, '0);

      // Back-to-back grants 2 then 3 (ROM_LAT=3 instance timing)
      do_reset();
      drive(4'b0100, 4'b0000, {15'h7ABC, 15'h1234, 30'h0});
      chk("b2b_g2", obs_gnt, 4'b0100);
      drive(4'b1000, 4'b0000, {15'h7ABC, 15'h1234, 30'h0});
      chk("b2b_g3", obs_gnt, 4'b1000);
      repeat (6) drive(4'b0000, 4'b0000, '0);

      // Randomized traffic; pending requesters stay high until granted
      for (int i = 0; i < 1500; i++) begin
         if (i < 750) r = (req & ~obs_gnt) | (4'($urandom) | 4'($urandom));
         else         r = (req & ~obs_gnt) | (4'($urandom) & 4'($urandom) & 4'($urandom));
         drive(r, 4'($urandom) | 4'($urandom), 60'({$urandom(), $urandom()}));
      end
      repeat (8) drive(4'b0000, 4'b0000, '0);

      chk("drain_rom", pa, gq.size());
      chk("drain_lat1", p1, gq.size());
      chk("drain_lat3", p3, gq.size());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
